// File: rtl/cpu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : cpu_fetch_queue
// Brief   : In-order MIPS fetch queue between the I-side memory port and decode;
//           CPU_FETCH_BYPASS_EN adds a same-cycle response-to-decode bypass.
// Revision: 1.0
// ============================================================================
module cpu_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 2;
  localparam logic [SW-1:0] C_DEPTH_SUM = SW'(DEPTH);
  localparam logic [CW-1:0] C_DEPTH_CNT = CW'(DEPTH);

  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [CW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;

  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic [SW-1:0] credit_used;
  logic          req_fire;
  logic          resp_live;
  logic          resp_drop;
  logic          bypass;
  logic          bypass_take;
  logic          push;
  logic          pop;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outst_base;
  logic [CW-1:0] drop_base;

  assign count       = wptr_q - rptr_q;
  assign empty       = (count == '0);
  assign full        = (count == C_DEPTH_CNT);
  assign credit_used = SW'(count) + SW'(outst_q) + SW'(drop_q);

  assign imem_req_valid = resetn && !redirect_valid && (credit_used < C_DEPTH_SUM);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_live = imem_resp_valid && (drop_q == '0);
  assign resp_drop = imem_resp_valid && (drop_q != '0);
  // Live in-flight requests are contiguous words ending just below fetch_pc.
  assign resp_pc   = fetch_pc_q - (32'(outst_q) << 2);

`ifdef CPU_FETCH_BYPASS_EN
  assign bypass     = empty && resp_live && !redirect_valid;
  assign inst_valid = !empty || bypass;
  assign inst       = empty ? imem_resp_data : data_q[rptr_q[AW-1:0]];
  assign inst_pc    = empty ? resp_pc : pc_q[rptr_q[AW-1:0]];
`else
  assign bypass     = 1'b0;
  assign inst_valid = !empty;
  assign inst       = data_q[rptr_q[AW-1:0]];
  assign inst_pc    = pc_q[rptr_q[AW-1:0]];
`endif

  assign pop         = !empty && inst_ready;
  assign bypass_take = bypass && inst_ready;
  assign push        = resp_live && !redirect_valid && !bypass_take;

  always_comb begin
    outst_base = outst_q + CW'(req_fire) - CW'(resp_live);
    drop_base  = drop_q - CW'(resp_drop);
    rptr_d     = rptr_q + CW'(pop);
    wptr_d     = wptr_q + CW'(push);
    outst_d    = outst_base;
    drop_d     = drop_base;
    fetch_pc_d = req_fire ? (fetch_pc_q + 32'd4) : fetch_pc_q;
    if (redirect_valid) begin
      // Everything still in flight is stale; its responses must be swallowed.
      wptr_d     = rptr_d;
      drop_d     = drop_base + outst_base;
      outst_d    = '0;
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wptr_q[AW-1:0]] <= imem_resp_data;
      pc_q[wptr_q[AW-1:0]]   <= resp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(push && full && !pop));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_fetch_queue
// Brief   : Scoreboard bench for cpu_fetch_queue with an in-order memory model.
// Revision: 1.0
// ============================================================================
module tb_cpu_fetch_queue;

  localparam int DEPTH = 4;
`ifdef CPU_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  always #5 clk = ~clk;

  cpu_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hBFC00000)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  typedef struct { logic [31:0] addr; bit stale; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  req_t        pend[$];
  exp_t        sb[$];
  int          cyc, last_due, n_checks, n_errors, n_pops;
  int          lat_min, lat_max;
  logic [31:0] exp_fetch_pc;
  bit          s_resp, s_req_valid, s_inst_valid, s_pop;
  logic [31:0] s_req_addr, s_pop_pc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hDEADBEEF;
  endfunction

  // One clock cycle: drive at negedge, sample 1ns later, update model, advance.
  task automatic cycle(input bit mem_rdy, input bit dec_rdy, input bit redir, input logic [31:0] rpc);
    req_t r;
    exp_t e;
    int   d;
    imem_req_ready  = mem_rdy;
    inst_ready      = dec_rdy;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    s_resp          = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_resp_valid = s_resp;
    imem_resp_data  = s_resp ? mem_data(pend[0].addr) : 32'h0;
    #1;
    s_req_valid  = imem_req_valid;
    s_req_addr   = imem_req_addr;
    s_inst_valid = inst_valid;
    s_pop        = inst_valid && dec_rdy;
    if (s_resp) begin
      r = pend.pop_front();
      if (!r.stale && !redir) sb.push_back('{pc: r.addr, data: mem_data(r.addr)});
    end
    if (redir) begin
      n_checks++;
      if (s_req_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL req_during_redirect: got %b want 0", s_req_valid);
      end
    end
    if (s_req_valid) begin
      n_checks++;
      if (s_req_addr !== exp_fetch_pc) begin
        n_errors++;
        $display("FAIL req_addr: got %h want %h (cyc %0d)", s_req_addr, exp_fetch_pc, cyc);
      end
      if (mem_rdy) begin
        d = cyc + $urandom_range(lat_max, lat_min);
        if (d < last_due) d = last_due;
        last_due = d;
        pend.push_back('{addr: s_req_addr, stale: 1'b0, due: d});
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
    end
    if (s_pop) begin
      n_checks++;
      n_pops++;
      s_pop_pc = inst_pc;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_inst: got pc %h data %h want none", inst_pc, inst);
      end else begin
        e = sb.pop_front();
        if (inst_pc !== e.pc || inst !== e.data) begin
          n_errors++;
          $display("FAIL inst: got pc %h data %h want pc %h data %h", inst_pc, inst, e.pc, e.data);
        end
      end
    end
    if (redir) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      sb.delete();
      exp_fetch_pc = rpc & 32'hFFFF_FFFC;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || pend.size() != 0) && n < 60) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      n++;
    end
    n_checks++;
    if (sb.size() != 0 || pend.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d words %0d pending want 0 0", sb.size(), pend.size());
    end
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (s_inst_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL drain_idle: got inst_valid %b want 0", s_inst_valid);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    imem_req_ready = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_req_valid: got %b want 0", imem_req_valid);
    end
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_inst_valid: got %b want 0", inst_valid);
    end
    resetn = 1'b1;
    exp_fetch_pc = 32'hBFC00000;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'hBFC00000) begin
      n_errors++;
      $display("FAIL first_req: got %b %h want 1 bfc00000", s_req_valid, s_req_addr);
    end
  endtask

  task automatic test_stream();
    int p0;
    lat_min = 1; lat_max = 1;
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    p0 = n_pops;
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (n_pops - p0 != 10) begin
      n_errors++;
      $display("FAIL throughput: got %0d words want 10", n_pops - p0);
    end
    drain();
  endtask

  task automatic test_stall();
    lat_min = 1; lat_max = 1;
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (s_req_valid !== 1'b0 || s_inst_valid !== 1'b1 || sb.size() != DEPTH) begin
      n_errors++;
      $display("FAIL stall_full: got req %b valid %b words %0d want 0 1 %0d",
               s_req_valid, s_inst_valid, sb.size(), DEPTH);
    end
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    drain();
  endtask

  task automatic test_redirect();
    int n = 0;
    bit got = 1'b0;
    lat_min = 2; lat_max = 2;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    while (pend.size() != 2 && n < 20) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    n_checks++;
    if (pend.size() != 2) begin
      n_errors++;
      $display("FAIL inflight_setup: got %0d want 2", pend.size());
    end
    cycle(1'b1, 1'b1, 1'b1, 32'h80000183);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h80000180) begin
      n_errors++;
      $display("FAIL redirect_addr: got %b %h want 1 80000180", s_req_valid, s_req_addr);
    end
    n = 0;
    while (!got && n < 20) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      got = s_pop;
      n++;
    end
    n_checks++;
    if (!got || s_pop_pc !== 32'h80000180) begin
      n_errors++;
      $display("FAIL redirect_first_pc: got %h (seen %b) want 80000180", s_pop_pc, got);
    end
    drain();
  endtask

  task automatic test_redirect_pop_resp();
    lat_min = 1; lat_max = 1;
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h00400000);
    n_checks++;
    if (s_inst_valid !== 1'b1 || s_resp !== 1'b1) begin
      n_errors++;
      $display("FAIL redirect_pop_resp_setup: got valid %b resp %b want 1 1", s_inst_valid, s_resp);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (s_inst_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL after_redirect_valid: got %b want 0", s_inst_valid);
    end
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    drain();
  endtask

  task automatic test_wrap();
    bit prev_top = 1'b0;
    bit seen = 1'b0;
    lat_min = 1; lat_max = 1;
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFFFFF8);
    repeat (6) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      if (prev_top && s_req_valid) begin
        seen = 1'b1;
        n_checks++;
        if (s_req_addr !== 32'h00000000) begin
          n_errors++;
          $display("FAIL wrap_addr: got %h want 00000000", s_req_addr);
        end
      end
      if (s_req_valid && s_req_addr == 32'hFFFFFFFC) prev_top = 1'b1;
      else if (s_req_valid) prev_top = 1'b0;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL wrap_seen: got 0 want 1");
    end
    drain();
  endtask

  task automatic test_bypass_latency();
    int n = 0;
    lat_min = 1; lat_max = 1;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    while (!s_resp && n < 10) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      n++;
    end
    n_checks++;
    if (!s_resp || s_inst_valid !== BYP) begin
      n_errors++;
      $display("FAIL bypass_latency: got resp %b inst_valid %b want 1 %b", s_resp, s_inst_valid, BYP);
    end
    drain();
  endtask

  task automatic test_random();
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99, 0) < 3)
        cycle(1'b1, 1'b1, 1'b1, $urandom());
      else
        cycle($urandom_range(3, 0) != 0, $urandom_range(9, 0) < 7, 1'b0, 32'h0);
    end
    drain();
  endtask

  initial begin
    cyc = 0; last_due = 0; n_checks = 0; n_errors = 0; n_pops = 0;
    lat_min = 1; lat_max = 1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_pop_resp();
    test_wrap();
    test_bypass_latency();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
